miss_handler_arb: RTL and testbench

Parametrised multi-channel miss handler front end. Accepts cache-miss read requests from NUM_CH cache channels, arbitrates them round-robin onto a single memory read port, tracks up to MAX_OUT outstanding reads, and routes each in-order memory response back to the channel that issued it. Sits between the per-channel caches and the DRAM read interface, generalising the single-channel fixed-latency miss path to N channels with bounded outstanding reads and full stall handling on both sides.

---
 rtl/miss_handler_arb_if.sv | 33 +++
 rtl/miss_handler_arb.sv | 150 +++++++++++++++
 tb/tb_miss_handler_arb.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/miss_handler_arb_if.sv
`default_nettype none
// miss_handler_arb_if: request, memory and response bundle for miss_handler_arb.
// Revision 1.0
interface miss_handler_arb_if #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 32,
  parameter int RDATA_W = 64
);
  logic [NUM_CH*ADDR_W-1:0] us_addr;
  logic [NUM_CH-1:0]        us_valid;
  logic [NUM_CH-1:0]        us_stall;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_valid;
  logic                     mem_stall;
  logic [RDATA_W-1:0]       mem_data;
  logic                     mem_rvalid;
  logic                     mem_rstall;
  logic [RDATA_W-1:0]       ds_data;
  logic [NUM_CH-1:0]        ds_valid;
  logic [NUM_CH-1:0]        ds_stall;
  logic                     err;

  modport slave (
    input  us_addr, us_valid, mem_stall, mem_data, mem_rvalid, ds_stall,
    output us_stall, mem_addr, mem_valid, mem_rstall, ds_data, ds_valid, err
  );

  modport master (
    output us_addr, us_valid, mem_stall, mem_data, mem_rvalid, ds_stall,
    input  us_stall, mem_addr, mem_valid, mem_rstall, ds_data, ds_valid, err
  );
endinterface
`default_nettype wire

// File: rtl/miss_handler_arb.sv
`default_nettype none
// miss_handler_arb: round-robin N-channel miss arbiter with in-order response routing.
// Revision 1.0
module miss_handler_arb #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 32,
  parameter int RDATA_W = 64,
  parameter int MAX_OUT = 8
) (
  input logic               clk,
  input logic               rst_n,
  miss_handler_arb_if.slave bus_io
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = PTR_W + 1;

  logic [CH_W-1:0]    rr_q, rr_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mem_valid_q, mem_valid_d;
  logic [CH_W-1:0]    id_fifo_q [MAX_OUT];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [RDATA_W-1:0] ds_data_q, ds_data_d;
  logic [NUM_CH-1:0]  ds_valid_q, ds_valid_d;
  logic [CH_W-1:0]    ds_ch_q, ds_ch_d;
  logic               err_q, err_d;

  logic               reg_free;
  logic               rstall;
  logic               rsp_acc;
  logic               pop;
  logic               can_grant;
  logic               found;
  logic               grant;
  logic [CH_W-1:0]    gnt_ch;
  logic [CH_W-1:0]    head_ch;
  logic [NUM_CH-1:0]  gnt_vec;
  logic [CNT_W-1:0]   cnt_after_pop;
  int                 scan_idx;

  assign head_ch       = id_fifo_q[rd_ptr_q];
  assign rstall        = (|ds_valid_q) & bus_io.ds_stall[ds_ch_q];
  assign rsp_acc       = bus_io.mem_rvalid & ~rstall;
  assign pop           = rsp_acc & (out_cnt_q != '0);
  // A pop this cycle frees a slot for a grant in the same cycle.
  assign cnt_after_pop = out_cnt_q - CNT_W'(pop);
  assign reg_free      = ~mem_valid_q | ~bus_io.mem_stall;
  assign can_grant     = reg_free & (cnt_after_pop < CNT_W'(MAX_OUT));
  assign grant         = found & can_grant;
  assign gnt_vec       = grant ? (NUM_CH'(1) << gnt_ch) : '0;

  always_comb begin
    found    = 1'b0;
    gnt_ch   = '0;
    scan_idx = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan_idx = (int'(rr_q) + k) % NUM_CH;
      if (!found && bus_io.us_valid[CH_W'(scan_idx)]) begin
        found  = 1'b1;
        gnt_ch = CH_W'(scan_idx);
      end
    end
  end

  always_comb begin
    rr_d        = rr_q;
    mem_addr_d  = mem_addr_q;
    mem_valid_d = mem_valid_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ds_data_d   = ds_data_q;
    ds_valid_d  = ds_valid_q;
    ds_ch_d     = ds_ch_q;
    err_d       = err_q;

    if (reg_free) begin
      mem_valid_d = grant;
      if (grant) begin
        mem_addr_d = bus_io.us_addr[int'(gnt_ch)*ADDR_W +: ADDR_W];
      end
    end
    if (grant) begin
      rr_d     = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + CH_W'(1);
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (!rstall) begin
      if (bus_io.mem_rvalid) begin
        if (out_cnt_q != '0) begin
          ds_data_d  = bus_io.mem_data;
          ds_valid_d = NUM_CH'(1) << head_ch;
          ds_ch_d    = head_ch;
          rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        end else begin
          // Orphan response: drop it and flag the protocol violation.
          ds_valid_d = '0;
          err_d      = 1'b1;
        end
      end else begin
        ds_valid_d = '0;
      end
    end

    out_cnt_d = out_cnt_q + CNT_W'(grant) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= '0;
      mem_addr_q  <= '0;
      mem_valid_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_cnt_q   <= '0;
      ds_data_q   <= '0;
      ds_valid_q  <= '0;
      ds_ch_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      mem_addr_q  <= mem_addr_d;
      mem_valid_q <= mem_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_cnt_q   <= out_cnt_d;
      ds_data_q   <= ds_data_d;
      ds_valid_q  <= ds_valid_d;
      ds_ch_q     <= ds_ch_d;
      err_q       <= err_d;
    end
  end

  // ID storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (grant) begin
      id_fifo_q[wr_ptr_q] <= gnt_ch;
    end
  end

  assign bus_io.us_stall   = bus_io.us_valid & ~gnt_vec;
  assign bus_io.mem_addr   = mem_addr_q;
  assign bus_io.mem_valid  = mem_valid_q;
  assign bus_io.mem_rstall = rstall;
  assign bus_io.ds_data    = ds_data_q;
  assign bus_io.ds_valid   = ds_valid_q;
  assign bus_io.err        = err_q;
endmodule
`default_nettype wire

// File: tb/tb_miss_handler_arb.sv
`default_nettype none
// tb_miss_handler_arb: randomized bench checked against a queue-based reference model.
// Revision 1.0
module tb_miss_handler_arb;
  localparam int NUM_CH  = 4;
  localparam int ADDR_W  = 32;
  localparam int RDATA_W = 64;
  localparam int MAX_OUT = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  miss_handler_arb_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .RDATA_W(RDATA_W)) bus_if ();

  miss_handler_arb #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .RDATA_W(RDATA_W),
    .MAX_OUT(MAX_OUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus_if)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  // Stimulus values
  logic [NUM_CH-1:0]  s_usv;
  logic [ADDR_W-1:0]  s_usa [NUM_CH];
  logic               s_mstall;
  logic               s_rv;
  logic [RDATA_W-1:0] s_rdata;
  logic [NUM_CH-1:0]  s_dss;

  // Reference model state
  int                 m_rr;
  int                 m_q[$];
  bit                 m_mv;
  logic [ADDR_W-1:0]  m_ma;
  bit                 m_dv;
  int                 m_dch;
  logic [RDATA_W-1:0] m_dd;
  bit                 m_err;
  int                 memacc;

  logic [NUM_CH-1:0]  prev_usv, prev_uss;
  bit                 prev_rv, prev_rst;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply();
    for (int c = 0; c < NUM_CH; c++) bus_if.us_addr[c*ADDR_W +: ADDR_W] = s_usa[c];
    bus_if.us_valid   = s_usv;
    bus_if.mem_stall  = s_mstall;
    bus_if.mem_rvalid = s_rv;
    bus_if.mem_data   = s_rdata;
    bus_if.ds_stall   = s_dss;
  endtask

  task automatic clear_stim();
    s_usv = '0; s_mstall = 1'b0; s_rv = 1'b0; s_rdata = '0; s_dss = '0;
    for (int c = 0; c < NUM_CH; c++) s_usa[c] = '0;
    apply();
  endtask

  task automatic model_reset();
    m_rr = 0; m_q.delete(); m_mv = 0; m_ma = '0; m_dv = 0; m_dch = 0;
    m_dd = '0; m_err = 0; memacc = 0;
    prev_usv = '0; prev_uss = '0; prev_rv = 0; prev_rst = 0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model across the edge.
  task automatic cycle();
    logic [NUM_CH-1:0] usv, dss, gvec, exp_uss;
    bit                load, popping, free;
    int                g, cnt_after;
    @(negedge clk);
    usv       = bus_if.us_valid;
    dss       = bus_if.ds_stall;
    load      = !m_dv || !dss[m_dch];
    popping   = bus_if.mem_rvalid && load && (m_q.size() > 0);
    free      = !m_mv || !bus_if.mem_stall;
    cnt_after = m_q.size() - (popping ? 1 : 0);
    g = -1;
    if (free && cnt_after < MAX_OUT) begin
      for (int k = 0; k < NUM_CH; k++) begin
        int c;
        c = (m_rr + k) % NUM_CH;
        if (g < 0 && usv[c]) g = c;
      end
    end
    gvec    = (g >= 0) ? (NUM_CH'(1) << g) : '0;
    exp_uss = usv & ~gvec;

    check_val("us_stall",   64'(bus_if.us_stall),   64'(exp_uss));
    check_val("mem_rstall", 64'(bus_if.mem_rstall), 64'(!load));
    check_val("mem_valid",  64'(bus_if.mem_valid),  64'(m_mv));
    check_val("mem_addr",   64'(bus_if.mem_addr),   64'(m_ma));
    check_val("ds_valid",   64'(bus_if.ds_valid),   m_dv ? 64'(1) << m_dch : 64'(0));
    check_val("ds_data",    64'(bus_if.ds_data),    64'(m_dd));
    check_val("err",        64'(bus_if.err),        64'(m_err));

    if (m_mv && !bus_if.mem_stall) memacc++;
    if (free) begin
      m_mv = (g >= 0);
      if (g >= 0) m_ma = s_usa[g];
    end
    if (g >= 0) m_rr = (g + 1) % NUM_CH;
    if (load) begin
      if (bus_if.mem_rvalid) begin
        if (m_q.size() > 0) begin
          m_dd  = bus_if.mem_data;
          m_dch = m_q.pop_front();
          m_dv  = 1;
          if (memacc > 0) memacc--;
        end else begin
          m_dv  = 0;
          m_err = 1;
        end
      end else begin
        m_dv = 0;
      end
    end
    if (g >= 0) m_q.push_back(g);
    prev_usv = usv; prev_uss = exp_uss; prev_rv = bus_if.mem_rvalid; prev_rst = !load;
    @(posedge clk);
    #1;
  endtask

  // Modes: 0 random, 1 full-rate no stalls, 2 memory silent, 3 heavy ds_stall,
  // 4 mem_stall held, 5 drain and inject orphan responses.
  task automatic gen_inputs(input int mode);
    for (int c = 0; c < NUM_CH; c++) begin
      if (!(prev_usv[c] && prev_uss[c])) begin
        if (mode == 1 || mode == 2 || mode == 4) s_usv[c] = 1'b1;
        else if (mode == 5) s_usv[c] = 1'b0;
        else s_usv[c] = ($urandom_range(0, 99) < 60);
        s_usa[c] = $urandom;
      end
    end
    if (mode == 4) s_mstall = 1'b1;
    else if (mode == 1 || mode == 2 || mode == 5) s_mstall = 1'b0;
    else s_mstall = ($urandom_range(0, 3) == 0);
    for (int c = 0; c < NUM_CH; c++) begin
      if (mode == 3) s_dss[c] = ($urandom_range(0, 99) < 70);
      else if (mode == 0) s_dss[c] = ($urandom_range(0, 3) == 0);
      else s_dss[c] = 1'b0;
    end
    if (!(prev_rv && prev_rst)) begin
      s_rdata = {$urandom, $urandom};
      if (mode == 2) s_rv = 1'b0;
      else if (mode == 5 && m_q.size() == 0 && memacc == 0) s_rv = 1'b1;
      else if (memacc > 0) s_rv = (mode == 1) ? 1'b1 : ($urandom_range(0, 1) == 1);
      else s_rv = 1'b0;
    end
    apply();
  endtask

  task automatic run(input int mode, input int n);
    for (int i = 0; i < n; i++) begin
      gen_inputs(mode);
      cycle();
    end
  endtask

  // Asynchronous reset away from any clock edge, with outputs checked before the next edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_mem_valid", 64'(bus_if.mem_valid), 64'(0));
    check_val("rst_mem_addr",  64'(bus_if.mem_addr),  64'(0));
    check_val("rst_ds_valid",  64'(bus_if.ds_valid),  64'(0));
    check_val("rst_ds_data",   64'(bus_if.ds_data),   64'(0));
    check_val("rst_err",       64'(bus_if.err),       64'(0));
    clear_stim();
    #1;
    check_val("rst_us_stall",   64'(bus_if.us_stall),   64'(0));
    check_val("rst_mem_rstall", 64'(bus_if.mem_rstall), 64'(0));
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_stim();
    model_reset();
    do_reset();

    // Single request from channel 2, then one response carrying 0xAA.
    s_usa[2] = 32'h100; s_usv = 4'b0100; apply();
    cycle();
    s_usv = '0; apply();
    cycle();
    check_val("dir_mem_addr", 64'(bus_if.mem_addr), 64'h100);
    cycle();
    s_rv = 1'b1; s_rdata = 64'hAA; apply();
    cycle();
    check_val("dir_ds_valid", 64'(bus_if.ds_valid), 64'(4'b0100));
    check_val("dir_ds_data",  64'(bus_if.ds_data),  64'hAA);
    s_rv = 1'b0; apply();
    cycle();

    run(1, 40);
    run(2, 20);
    run(1, 10);
    run(3, 60);
    run(4, 8);
    run(0, 300);
    run(5, 40);
    check_val("err_sticky", 64'(bus_if.err), 64'(1));
    run(0, 50);
    do_reset();
    run(0, 300);
    run(2, 15);
    run(5, 40);
    do_reset();
    run(0, 200);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
`default_nettype wire
